// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Division by zero completes in one cycle with quotient all ones and remainder = dividend.
module seq_restoring_divider #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W:0]    r_q, r_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [W:0]    r_sh, r_sub, r_nxt;
  logic [W-1:0]  q_nxt;

  // One restoring step: shift {R,Q} left, trial-subtract, keep or restore.
  always_comb begin
    r_sh  = {r_q[W-1:0], q_q[W-1]};
    r_sub = r_sh - {1'b0, dvs_q};
    if (r_sub[W]) begin
      r_nxt = r_sh;
      q_nxt = {q_q[W-2:0], 1'b0};
    end else begin
      r_nxt = r_sub;
      q_nxt = {q_q[W-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            r_d     = '0;
            q_d     = dividend;
            dvs_d   = divisor;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d = r_nxt;
        q_d = q_nxt;
        if (cnt_q == LAST) begin
          quot_d  = q_nxt;
          rem_d   = r_nxt[W-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered copies of the next state so they never glitch.
    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
Sequential unsigned restoring divider. It is the inverse arithmetic operation of the team's combinational Wallace-tree multiplier. It takes a W-bit dividend and divisor, and after a start/busy/done handshake returns a W-bit quotient and W-bit remainder. One quotient bit is produced per clock. It sits beside the multiplier in the arithmetic datapath so that P = a*b results can be divided back down.

Parameters:
W, 4, operand width in bits (dividend, divisor, quotient, remainder); legal range 2..16.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled on a rising edge when the block is not busy
dividend  input  W  unsigned dividend; sampled with start
divisor  input  W  unsigned divisor; sampled with start
busy  output  1  high while an operation is in progress (CALC state)
done  output  1  one-cycle pulse; quotient/remainder/div_by_zero are valid from this cycle on
quotient  output  W  unsigned quotient
remainder  output  W  unsigned remainder
div_by_zero  output  1  high with done when the sampled divisor was 0

Behaviour:
- Reset (rst=1 at a rising edge, regardless of state):
  - state to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal counter and working registers cleared.
  - Reset mid-operation aborts the operation; no done is issued.
- States: IDLE, CALC, DONE. busy = (state==CALC); done = (state==DONE). Both are registered and glitch-free.
- IDLE:
  - start=1 and divisor!=0: latch operands; load working remainder R (W+1 bits) with 0 and Q with the dividend; count=0; go to CALC.
  - start=1 and divisor==0: go straight to DONE with quotient = all ones, remainder = dividend, div_by_zero=1. Latency is 1 cycle.
- CALC, one iteration per edge, W iterations total:
  - {R,Q} shifts left by 1 (MSB of Q enters the LSB of R).
  - T = R_shifted - {1'b0,divisor}, computed in W+1 bits.
  - If T is non-negative (MSB of T = 0): R <= T, Q LSB <= 1. Otherwise R is restored (keeps the shifted value) and Q LSB <= 0.
  - When count==W-1, the final iteration result is written to the quotient/remainder outputs (remainder = R[W-1:0]), div_by_zero=0, and the state goes to DONE. Otherwise count increments.
- Latency: the start edge is E0. done is high in the cycle following edge EW, i.e. W clock cycles after start is sampled.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - start=1 in the DONE cycle is accepted exactly as in IDLE (back-to-back operation).
- start while busy (CALC) is ignored; the in-flight operation and its inputs are unaffected.
- dividend/divisor may change freely after the start edge; only the sampled values are used.
- quotient, remainder and div_by_zero hold their last values until the next completion or reset. They do not change during CALC.
- Invariant for divisor!=0: dividend == quotient*divisor + remainder, with remainder < divisor.
- Boundary cases:
  - dividend < divisor gives quotient=0, remainder=dividend.
  - divisor=1 gives quotient=dividend, remainder=0.
  - dividend=0 gives 0,0.
  - Max operands: for W=4, 15/15 gives 1,0.

Test Plan:
- W=4, start with dividend=13, divisor=3 -> busy high 4 cycles; done pulses exactly 4 cycles after the start edge; quotient=4, remainder=1, div_by_zero=0.
- Exhaustive W=4: all 16x15 nonzero-divisor pairs, back-to-back starts asserted during DONE -> every result matches q=a/b, r=a%b; no idle cycle between operations.
- dividend=9, divisor=0 -> done 1 cycle after start; quotient=15, remainder=9, div_by_zero=1. Next op 15/1 -> quotient=15, remainder=0, div_by_zero=0.
- Start 14/4; in cycle 2 pulse start with 7/7 and change the inputs -> second start ignored; result quotient=3, remainder=2; no extra done.
- Start 11/2; assert rst in cycle 2 -> all outputs 0, busy=0, no done. Then start 2/7 -> quotient=0, remainder=2 after 4 cycles.
- Hold outputs: after 13/3 completes, idle 10 cycles with random dividend/divisor and start=0 -> quotient=4 and remainder=1 stable; done stays 0.
